// File: rtl/ibex_ascon_round_sequencer.sv
// Multi-cycle sequencer for the combinational Ascon permutation core.
// Holds the 320-bit state, feeds the core one batch of up to UNROLLED_ROUNDS
// rounds per cycle with the matching round constant, and returns the result
// through a valid/ready response channel. The state is treated as opaque bits.
// perm_meta_o layout: [10:3] = roundconstant, [2:0] = rounds (batch size - 1).
module ibex_ascon_round_sequencer #(
    parameter int unsigned UNROLLED_ROUNDS          = 1,
    parameter bit          INTERMEDIATE_MULTIPLEXER = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  logic [319:0]   req_state_i,
    input  logic [3:0]     req_rounds_i,
    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic [319:0]   rsp_state_o,
    output logic           rsp_err_o,
    output logic           busy_o,
    output logic           perm_en_o,
    output logic [10:0]    perm_meta_o,
    output logic [319:0]   perm_state_o,
    input  logic [319:0]   perm_state_i
);

    localparam logic [3:0] UNROLL     = 4'(UNROLLED_ROUNDS);
    localparam logic [3:0] MAX_ROUNDS = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_e;

    fsm_e         fsm_q;
    logic [319:0] state_q;
    logic [3:0]   remaining_q;
    logic [3:0]   rc_idx_q;
    logic         err_q;
    logic         req_ready_q;
    logic         rsp_valid_q;
    logic         busy_q;
    logic         perm_en_q;

    logic         rounds_legal;
    logic [3:0]   batch;
    logic [2:0]   batch_rounds;
    logic [3:0]   rc_hi;

    // Decide whether the requested round count can be executed by this core
    always_comb begin
        // NOTE: every signal driven here gets a value before any condition, so
        // no path leaves it unassigned and no latch is inferred.
        rounds_legal = (req_rounds_i != 4'd0) && (req_rounds_i <= MAX_ROUNDS);
        if (!INTERMEDIATE_MULTIPLEXER && ((req_rounds_i % UNROLL) != 4'd0)) begin
            rounds_legal = 1'b0;
        end
    end

    // Size of the current batch and the constant of its first round
    always_comb begin
        batch        = (remaining_q < UNROLL) ? remaining_q : UNROLL;
        batch_rounds = 3'(batch - 4'd1);
        rc_hi        = 4'hF - rc_idx_q;
    end

    // Core interface is gated so nothing toggles toward the core when idle
    assign perm_meta_o  = perm_en_q ? {rc_hi, ~rc_hi, batch_rounds} : 11'd0;
    assign perm_state_o = perm_en_q ? state_q : 320'd0;

    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_state_o  = state_q;
    assign rsp_err_o    = err_q;
    assign busy_o       = busy_q;
    assign perm_en_o    = perm_en_q;

    // Control FSM with registered handshake/enable outputs
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses <= so each register samples the values
        // from before the edge, independent of statement order.
        if (rst_i || flush_i) begin
            fsm_q       <= ST_IDLE;
            // NOTE: the wide state register is cleared too, so an aborted
            // permutation leaves no intermediate state behind.
            state_q     <= 320'd0;
            remaining_q <= 4'd0;
            rc_idx_q    <= 4'd0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            perm_en_q   <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        state_q     <= req_state_i;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (rounds_legal) begin
                            remaining_q <= req_rounds_i;
                            rc_idx_q    <= MAX_ROUNDS - req_rounds_i;
                            err_q       <= 1'b0;
                            perm_en_q   <= 1'b1;
                            fsm_q       <= ST_RUN;
                        end else begin
                            // Illegal request: echo the state back with an error
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            fsm_q       <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    state_q     <= perm_state_i;
                    remaining_q <= remaining_q - batch;
                    rc_idx_q    <= rc_idx_q + batch;
                    if (remaining_q == batch) begin
                        perm_en_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        fsm_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        fsm_q       <= ST_IDLE;
                    end
                end
                default: begin
                    fsm_q       <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    perm_en_q   <= 1'b0;
                end
            endcase
        end
    end

    // Protocol invariants
    a_rsp_excludes_req: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_valid_o |-> !req_ready_o);
    a_en_only_in_run: assert property (@(posedge clk_i) disable iff (rst_i)
        perm_en_o |-> (fsm_q == ST_RUN));
    a_rc_idx_range: assert property (@(posedge clk_i) disable iff (rst_i)
        rc_idx_q <= MAX_ROUNDS);
    a_full_batches: assert property (@(posedge clk_i) disable iff (rst_i)
        (perm_en_o && !INTERMEDIATE_MULTIPLEXER) |-> (perm_meta_o[2:0] == 3'(UNROLLED_ROUNDS - 1)));

endmodule

// File: doc/ibex_ascon_round_sequencer.md
Name: ibex_ascon_round_sequencer

Overview:
- Multi-cycle controller that drives the combinational Ascon permutation core (ibex_asconp) to execute a full p^a permutation, a = 1..12.
- Holds the 320-bit Ascon state in a register and issues one batch of up to UNROLLED_ROUNDS rounds per cycle.
- Generates the per-batch round constant and round-count metadata, then returns the result through a valid/ready response channel.
- Sits between the Ascon instruction decode/register-file path (upstream) and ibex_asconp (downstream).

Parameters:
- UNROLLED_ROUNDS, 1, rounds evaluated per cycle. Must match the attached permutation core; legal range 1..8.
- INTERMEDIATE_MULTIPLEXER, 0, set to 1 when the attached core can output a partial batch (rounds field < UNROLLED_ROUNDS-1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  abort any operation and return to IDLE.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_state_i  in  320  input state, ascon_state_t.
- req_rounds_i  in  4  number of rounds a; legal 1..12.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_state_o  out  320  result state, ascon_state_t.
- rsp_err_o  out  1  request was illegal; state returned unchanged.
- busy_o  out  1  high in RUN or DONE.
- perm_en_o  out  1  instruction enable to the core.
- perm_meta_o  out  ascon_meta_t  fields: roundconstant[7:0] and rounds[2:0].
- perm_state_o  out  320  state to the core.
- perm_state_i  in  320  state from the core.

Behaviour:
- Reset and flush values: FSM=IDLE; state_q=0; remaining_q=0; rc_idx_q=0; err_q=0.
- Reset and flush outputs: req_ready_o=1, rsp_valid_o=0, busy_o=0, perm_en_o=0, perm_meta_o=0.
- flush_i has priority over all other events except rst_i.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch req_state_i into state_q.
  - Legal a (1..12), and, when INTERMEDIATE_MULTIPLEXER=0, a mod UNROLLED_ROUNDS == 0:
    - remaining_q = a; rc_idx_q = 12 - a; err_q = 0; go to RUN.
  - Otherwise: err_q = 1; go straight to DONE with state unchanged.
  - Illegal a includes 0, 13, 14 and 15.
- RUN:
  - req_ready_o = 0; perm_en_o = 1; perm_state_o = state_q.
  - Batch size n = min(remaining_q, UNROLLED_ROUNDS).
  - perm_meta_o.rounds = n - 1 (3-bit).
  - perm_meta_o.roundconstant = {4'hF - rc_idx_q, ~(4'hF - rc_idx_q)}.
  - Each cycle: state_q <= perm_state_i; remaining_q -= n; rc_idx_q += n (4-bit, never exceeds 12).
  - When remaining_q == n, go to DONE.
  - RUN lasts exactly ceil(a / UNROLLED_ROUNDS) cycles.
- DONE:
  - rsp_valid_o = 1; rsp_state_o = state_q; rsp_err_o = err_q; perm_en_o = 0.
  - On rsp_ready_i, go to IDLE.
  - rsp_state_o and rsp_err_o stay stable while rsp_valid_o && !rsp_ready_i.
- Throughput:
  - No new request is accepted before the response handshake.
  - From IDLE with rsp_ready_i tied high: accept at cycle 0, rsp_valid_o at cycle ceil(a/U)+1, req_ready_o again at cycle ceil(a/U)+2.
- perm_state_o = 0 whenever perm_en_o = 0; no toggling when idle.
- perm_meta_o is fully combinational from registers only; no path from perm_state_i to any output except via state_q.
- Endianness conversion is the core's responsibility; this block treats state as opaque 320 bits.
- Assertions:
  - rsp_valid_o implies !req_ready_o.
  - perm_en_o implies FSM==RUN.
  - rc_idx_q ≤ 12.
  - When INTERMEDIATE_MULTIPLEXER=0, perm_meta_o.rounds == UNROLLED_ROUNDS-1 whenever perm_en_o.

Test Plan:
- U=1, a=12, state=0, rsp_ready_i=1:
  - 12 RUN cycles with roundconstant sequence F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B.
  - rsp_state_o equals the golden Ascon p12(0); rsp_err_o=0.
- U=1, a=6 -> 6 RUN cycles, constants 96..4B; a=8 -> first constant B4.
- U=4, INTERMEDIATE_MULTIPLEXER=1, a=6:
  - Two RUN cycles: (rounds=3, rc=96) then (rounds=1, rc=5A).
  - Result matches golden p6.
- U=4, INTERMEDIATE_MULTIPLEXER=0:
  - a=6 -> DONE after 1 cycle, rsp_err_o=1, rsp_state_o=req_state_i.
  - a=0 and a=13 give the same error response.
- Backpressure: hold rsp_ready_i=0 for 5 cycles in DONE.
  - rsp_valid_o stays 1, outputs stable, req_ready_o stays 0.
  - A req_valid_i pulse during this time is not accepted.
- flush_i asserted in the 3rd RUN cycle of p12 -> next cycle IDLE, perm_en_o=0, rsp_valid_o never asserted. rst_i mid-RUN gives the same result plus state_q=0.
